// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo
// -----------------------------------------------------------------------------
// Byte-buffering feeder placed directly in front of a serial transmitter.
// Producers push bytes with a single-cycle write strobe. Bytes are held in a
// circular FIFO and launched to the transmitter one at a time. Each byte is
// launched with a one-cycle o_Tx_DV pulse. The next launch waits until the
// transmitter's done handshake has completed.
//
// Ports
//   i_Clock      system clock, rising edge
//   i_Reset      synchronous, active-high reset
//   i_Wr_DV      write strobe, one byte per cycle
//   i_Wr_Byte    write data
//   o_Full       FIFO holds DEPTH bytes
//   o_Empty      FIFO holds no bytes
//   o_Count      occupancy, 0..DEPTH
//   o_Overflow   sticky; set by a write that was dropped because the FIFO was full
//   o_Tx_DV      one-cycle launch pulse to the transmitter
//   o_Tx_Byte    byte being launched; held until the next launch
//   i_Tx_Active  transmitter busy
//   i_Tx_Done    transmitter done; may stay high for 1-2 cycles
//   o_Dbg_State  current launch FSM state (state_e encoding)
//
// Handshake: a launch (o_Tx_DV=1, o_Tx_Byte valid) is issued only from S_IDLE,
// and only while the transmitter shows i_Tx_Active=0 and i_Tx_Done=0. After a
// launch, the FSM waits for i_Tx_Done to rise and then fall before it can issue
// another launch. As a result, at most one launch is outstanding per done
// handshake.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              i_Clock,
  input  logic              i_Reset,
  input  logic              i_Wr_DV,
  input  logic [7:0]        i_Wr_Byte,
  output logic              o_Full,
  output logic              o_Empty,
  output logic [ADDR_W:0]   o_Count,
  output logic              o_Overflow,
  output logic              o_Tx_DV,
  output logic [7:0]        o_Tx_Byte,
  input  logic              i_Tx_Active,
  input  logic              i_Tx_Done,
  output logic [1:0]        o_Dbg_State
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_LAUNCH    = 2'd1,
    S_WAIT_DONE = 2'd2,
    S_RELEASE   = 2'd3
  } state_e;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              tx_dv_q, tx_dv_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic [7:0]        mem_q [DEPTH];

  logic full, empty, pop, wr_accept;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Launch FSM
  always_comb begin
    state_d   = state_q;
    tx_dv_d   = 1'b0;
    tx_byte_d = tx_byte_q;
    pop       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty && !i_Tx_Active && !i_Tx_Done) begin
          pop       = 1'b1;
          tx_dv_d   = 1'b1;
          tx_byte_d = mem_q[rd_ptr_q];
          state_d   = S_LAUNCH;
        end
      end
      S_LAUNCH:    state_d = S_WAIT_DONE;
      // i_Tx_Active is deliberately ignored here; only done ends a frame.
      S_WAIT_DONE: if (i_Tx_Done) state_d = S_RELEASE;
      // Done may be held for more than one cycle. Wait for it to drop so a
      // single done pulse cannot release two launches.
      S_RELEASE:   if (!i_Tx_Done) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // FIFO bookkeeping. A pop in the same cycle frees a slot, so a write while
  // full is still accepted in that cycle.
  always_comb begin
    wr_accept  = i_Wr_DV && (!full || pop);
    overflow_d = overflow_q || (i_Wr_DV && full && !pop);
    wr_ptr_d   = wr_accept ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d   = pop ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    count_d    = count_q;
    case ({wr_accept, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      state_q    <= S_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      tx_dv_q    <= 1'b0;
      tx_byte_q  <= 8'h00;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      tx_dv_q    <= tx_dv_d;
      tx_byte_q  <= tx_byte_d;
    end
  end

  // Storage is not reset. Stale contents are unreachable once the pointers clear.
  always_ff @(posedge i_Clock) begin
    if (wr_accept) mem_q[wr_ptr_q] <= i_Wr_Byte;
  end

  assign o_Full      = full;
  assign o_Empty     = empty;
  assign o_Count     = count_q;
  assign o_Overflow  = overflow_q;
  assign o_Tx_DV     = tx_dv_q;
  assign o_Tx_Byte   = tx_byte_q;
  assign o_Dbg_State = state_q;

endmodule
